// File: rtl/dram_req_arbiter.sv
// rtl/dram_req_arbiter.sv - round-robin arbiter sharing one burst DRAM among PIM requesters
module dram_req_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 32,
    parameter int BURST_LEN   = 4,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ-1:0]                req_we,
    input  logic [NUM_REQ*ADDR_W-1:0]         req_addr,
    input  logic [NUM_REQ*DATA_W*BURST_LEN-1:0] req_wdata,
    output logic [NUM_REQ-1:0]                req_ready,
    output logic [NUM_REQ-1:0]                rsp_valid,
    output logic [DATA_W-1:0]                 rsp_data,
    output logic                              rsp_last,
    output logic [NUM_REQ-1:0]                done,
    output logic                              timeout_err,
    output logic                              mem_read_en,
    output logic                              mem_write_en,
    output logic [ADDR_W-1:0]                 mem_addr,
    output logic [DATA_W-1:0]                 mem_wdata,
    input  logic                              mem_ready,
    input  logic                              mem_valid,
    input  logic [DATA_W-1:0]                 mem_rdata,
    input  logic                              mem_complete
);
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int WD_W   = $clog2(TIMEOUT_CYC) + 1;
    localparam int BUF_W  = DATA_W * BURST_LEN;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;
    state_t state, state_nxt;

    logic [IDX_W-1:0]  last_grant, owner, winner;
    logic              found;
    logic              we_q;
    logic [BUF_W-1:0]  wbuf;
    logic [BEAT_W-1:0] rbeat, wbeat;
    logic              r_fin;
    logic [WD_W-1:0]   wd_cnt;
    logic              accept, finish, wd_fire, rd_beat;

    // Rotating priority: search starts just above the last winner and wraps.
    always_comb begin
        int cand;
        cand   = 0;
        winner = '0;
        found  = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = int'(last_grant) + i;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!found && req_valid[IDX_W'(cand)]) begin
                found  = 1'b1;
                winner = IDX_W'(cand);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        finish    = 1'b0;
        wd_fire   = 1'b0;
        rd_beat   = 1'b0;
        req_ready = '0;
        rsp_valid = '0;
        rsp_last  = 1'b0;
        case (state)
            IDLE: begin
                if (rst && mem_ready && found) begin
                    accept            = 1'b1;
                    req_ready[winner] = 1'b1;
                    state_nxt         = BUSY;
                end
            end
            BUSY: begin
                // r_fin blocks strobes beyond the burst once the last beat was delivered.
                rd_beat = mem_valid && !we_q && !r_fin;
                if (rd_beat) begin
                    rsp_valid[owner] = 1'b1;
                    rsp_last         = (rbeat == LAST_BEAT);
                end
                if (mem_complete) begin
                    finish = 1'b1;
                end else if (wd_cnt == WD_W'(TIMEOUT_CYC - 1)) begin
                    finish  = 1'b1;
                    wd_fire = 1'b1;
                end
                if (finish) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (mem_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        rsp_data = rd_beat ? mem_rdata : '0;
    end

    assign mem_wdata = wbuf[wbeat*DATA_W +: DATA_W];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant   <= IDX_W'(NUM_REQ - 1);
            owner        <= '0;
            we_q         <= 1'b0;
            wbuf         <= '0;
            rbeat        <= '0;
            wbeat        <= '0;
            r_fin        <= 1'b0;
            wd_cnt       <= '0;
            done         <= '0;
            timeout_err  <= 1'b0;
            mem_read_en  <= 1'b0;
            mem_write_en <= 1'b0;
            mem_addr     <= '0;
        end else begin
            done <= '0;
            if (accept) begin
                owner        <= winner;
                last_grant   <= winner;
                we_q         <= req_we[winner];
                mem_addr     <= req_addr[winner*ADDR_W +: ADDR_W];
                wbuf         <= req_wdata[winner*BUF_W +: BUF_W];
                mem_read_en  <= ~req_we[winner];
                mem_write_en <= req_we[winner];
                rbeat        <= '0;
                wbeat        <= '0;
                r_fin        <= 1'b0;
                wd_cnt       <= '0;
            end
            if (state == BUSY) begin
                if (finish) begin
                    mem_read_en  <= 1'b0;
                    mem_write_en <= 1'b0;
                    done[owner]  <= 1'b1;
                    if (wd_fire) timeout_err <= 1'b1;
                end else begin
                    wd_cnt <= wd_cnt + 1'b1;
                end
                if (rd_beat) begin
                    if (rbeat == LAST_BEAT) r_fin <= 1'b1;
                    else                    rbeat <= rbeat + 1'b1;
                end
                if (mem_valid && we_q && wbeat != LAST_BEAT) wbeat <= wbeat + 1'b1;
            end
            if (state == DRAIN && mem_ready) begin
                rbeat  <= '0;
                wbeat  <= '0;
                r_fin  <= 1'b0;
                wd_cnt <= '0;
            end
        end
    end
endmodule
